// File: rtl/mod_exp_ctrl_if.sv
// Bus between the exponentiation sequencer (master) and the shared Montgomery
// multiplier (slave): operands out, start/done handshake and product back.
interface mod_exp_ctrl_if #(
    parameter int WIDTH = 1024
);
    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_m;
    logic [WIDTH-1:0] mul_result;
    logic             mul_done;

    modport master (
        output mul_start, mul_a, mul_b, mul_m,
        input  mul_result, mul_done
    );

    modport slave (
        input  mul_start, mul_a, mul_b, mul_m,
        output mul_result, mul_done
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing x^e mod M in the
// Montgomery domain, issuing one multiplication at a time to an external core.
module mod_exp_ctrl #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024,
    parameter int LEN_W     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [LEN_W-1:0]     in_e_len,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    mod_exp_ctrl_if.master       mul_bus
);

    localparam int               IDX_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(EXP_WIDTH);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOMONT_ISS,
        S_TOMONT_WAIT,
        S_SQ_ISS,
        S_SQ_WAIT,
        S_MUL_ISS,
        S_MUL_WAIT,
        S_FROM_ISS,
        S_FROM_WAIT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [EXP_WIDTH-1:0]   e_q;
    logic                   len_zero_q;
    logic [IDX_W-1:0]       idx_q;
    logic [WIDTH-1:0]       acc_q;
    logic [WIDTH-1:0]       xt_q;

    logic [LEN_W-1:0]       len_clamped;
    logic [LEN_W-1:0]       len_m1;
    logic                   accept;
    logic                   ld_ops;
    logic [WIDTH-1:0]       op_a_d;
    logic [WIDTH-1:0]       op_b_d;
    logic                   acc_ld;
    logic                   xt_ld;
    logic                   idx_dec;
    logic                   res_ld;

    assign len_clamped = (in_e_len > LEN_MAX) ? LEN_MAX : in_e_len;
    assign len_m1      = len_clamped - LEN_W'(1);

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done              = (state_q == S_DONE);
    assign mul_bus.mul_start = (state_q == S_TOMONT_ISS) || (state_q == S_SQ_ISS) ||
                               (state_q == S_MUL_ISS)    || (state_q == S_FROM_ISS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the operand pair for the following multiplication,
    // decided in the cycle the current product arrives.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ld_ops  = 1'b0;
        op_a_d  = mul_bus.mul_result;
        op_b_d  = mul_bus.mul_result;
        acc_ld  = 1'b0;
        xt_ld   = 1'b0;
        idx_dec = 1'b0;
        res_ld  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_TOMONT_ISS;
                end
            end
            S_TOMONT_ISS: state_d = S_TOMONT_WAIT;
            S_TOMONT_WAIT: begin
                if (mul_bus.mul_done) begin
                    xt_ld  = 1'b1;
                    ld_ops = 1'b1;
                    op_a_d = acc_q;
                    if (len_zero_q) begin
                        op_b_d  = ONE;
                        state_d = S_FROM_ISS;
                    end else begin
                        op_b_d  = acc_q;
                        state_d = S_SQ_ISS;
                    end
                end
            end
            S_SQ_ISS: state_d = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (mul_bus.mul_done) begin
                    acc_ld = 1'b1;
                    ld_ops = 1'b1;
                    if (e_q[idx_q]) begin
                        op_b_d  = xt_q;
                        state_d = S_MUL_ISS;
                    end else if (idx_q == '0) begin
                        op_b_d  = ONE;
                        state_d = S_FROM_ISS;
                    end else begin
                        idx_dec = 1'b1;
                        state_d = S_SQ_ISS;
                    end
                end
            end
            S_MUL_ISS: state_d = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mul_bus.mul_done) begin
                    acc_ld = 1'b1;
                    ld_ops = 1'b1;
                    if (idx_q == '0) begin
                        op_b_d  = ONE;
                        state_d = S_FROM_ISS;
                    end else begin
                        idx_dec = 1'b1;
                        state_d = S_SQ_ISS;
                    end
                end
            end
            S_FROM_ISS: state_d = S_FROM_WAIT;
            S_FROM_WAIT: begin
                if (mul_bus.mul_done) begin
                    res_ld  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The first multiplication's operands (x, R^2 mod M) go straight into the
    // operand registers at accept, so x and R^2 need no separate storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q             <= '0;
            len_zero_q      <= 1'b0;
            idx_q           <= '0;
            acc_q           <= '0;
            xt_q            <= '0;
            result          <= '0;
            mul_bus.mul_a   <= '0;
            mul_bus.mul_b   <= '0;
            mul_bus.mul_m   <= '0;
        end else begin
            if (accept) begin
                e_q           <= in_e;
                len_zero_q    <= (len_clamped == '0);
                idx_q         <= len_m1[IDX_W-1:0];
                acc_q         <= in_r;
                mul_bus.mul_a <= in_x;
                mul_bus.mul_b <= in_r2;
                mul_bus.mul_m <= in_m;
            end
            if (ld_ops) begin
                mul_bus.mul_a <= op_a_d;
                mul_bus.mul_b <= op_b_d;
            end
            if (xt_ld) begin
                xt_q <= mul_bus.mul_result;
            end
            if (acc_ld) begin
                acc_q <= mul_bus.mul_result;
            end
            if (idx_dec) begin
                idx_q <= idx_q - IDX_W'(1);
            end
            if (res_ld) begin
                result <= mul_bus.mul_result;
            end
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with a fixed-latency behavioural
// Montgomery multiplier (WIDTH=8, M=13, R=256).
module tb_mod_exp_ctrl;

    localparam int W    = 8;
    localparam int EW   = 16;
    localparam int LW   = 11;
    localparam int LAT  = 5;
    localparam int MOD  = 13;
    localparam int RMOD = 9;
    localparam int R2   = 3;
    // 256^-1 mod 13 is 3 because 9*3 = 27 = 1 mod 13.
    localparam int RINV = 3;

    typedef struct {
        logic [W-1:0]  x;
        logic [EW-1:0] e;
        logic [LW-1:0] e_len;
        bit            poke;
        int            exp_result;
        int            exp_muls;
        int            exp_cycle;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  in_x;
    logic [EW-1:0] in_e;
    logic [LW-1:0] in_e_len;
    logic [W-1:0]  in_m;
    logic [W-1:0]  in_r;
    logic [W-1:0]  in_r2;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;

    mod_exp_ctrl_if #(.WIDTH(W)) mbus();

    mod_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_x     (in_x),
        .in_e     (in_e),
        .in_e_len (in_e_len),
        .in_m     (in_m),
        .in_r     (in_r),
        .in_r2    (in_r2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mul_bus  (mbus.master)
    );

    always #5 clk = ~clk;

    function automatic int mont(input int a, input int b);
        return (a * b * RINV) % MOD;
    endfunction

    function automatic int ref_len(input int len);
        return (len > EW) ? EW : len;
    endfunction

    // Right-to-left plain modular power over the low len bits of e.
    function automatic int ref_pow(input int x, input logic [EW-1:0] e, input int len);
        int r = 1;
        int p = x % MOD;
        for (int i = 0; i < ref_len(len); i++) begin
            if (e[i]) r = (r * p) % MOD;
            p = (p * p) % MOD;
        end
        return r;
    endfunction

    function automatic int ref_muls(input logic [EW-1:0] e, input int len);
        int n = 2 + ref_len(len);
        for (int i = 0; i < ref_len(len); i++) n += e[i] ? 1 : 0;
        return n;
    endfunction

    // Multiplier model: mul_done LAT cycles after mul_start; flags operand drift.
    int          mul_starts = 0;
    int          stab_bad   = 0;
    int          late_dones = 0;
    logic        pend       = 1'b0;
    logic        aborted    = 1'b0;
    int          cnt        = 0;
    logic [W-1:0] cap_a, cap_b, cap_m;

    always @(posedge clk) begin
        mbus.mul_done <= 1'b0;
        if (mbus.mul_start === 1'b1) mul_starts <= mul_starts + 1;
        if (mbus.mul_done === 1'b1) begin
            if (aborted) late_dones <= late_dones + 1;
            else if (mbus.mul_a !== cap_a || mbus.mul_b !== cap_b ||
                     mbus.mul_m !== cap_m || cap_m !== W'(MOD))
                stab_bad <= stab_bad + 1;
            aborted <= 1'b0;
        end
        if (pend) begin
            if (reset) aborted <= 1'b1;
            if (cnt == 1) begin
                mbus.mul_done   <= 1'b1;
                mbus.mul_result <= W'(mont(int'(cap_a), int'(cap_b)));
                pend            <= 1'b0;
            end
            cnt <= cnt - 1;
        end
        if (mbus.mul_start === 1'b1) begin
            pend  <= 1'b1;
            cnt   <= LAT - 1;
            cap_a <= mbus.mul_a;
            cap_b <= mbus.mul_b;
            cap_m <= mbus.mul_m;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Runs one exponentiation; cycle 0 is the cycle start is sampled.
    task automatic apply_stimulus(input logic [W-1:0] x, input logic [EW-1:0] e,
                                  input logic [LW-1:0] len, input bit poke,
                                  output int got_result, output int got_muls,
                                  output int got_cycle, output int first_ok,
                                  output int busy_ok, output int pulse_ok,
                                  output int stab_delta);
        int snap_starts;
        int snap_stab;
        @(negedge clk);
        in_x = x; in_e = e; in_e_len = len; start = 1'b1;
        snap_starts = mul_starts;
        snap_stab   = stab_bad;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        first_ok   = (mbus.mul_start === 1'b1 && busy === 1'b1) ? 1 : 0;
        busy_ok    = 1;
        got_cycle  = -1;
        got_result = -1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (done === 1'b1) begin
                got_cycle  = cyc;
                got_result = int'(result);
                if (busy !== 1'b0) busy_ok = 0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 0;
            if (poke && cyc == 10) begin
                start = 1'b1; in_x = 8'd7; in_e = 16'hFFFF; in_e_len = 11'd9;
            end else begin
                start = 1'b0; in_x = x; in_e = e; in_e_len = len;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        got_muls = mul_starts - snap_starts;
        @(negedge clk);
        pulse_ok   = (done === 1'b0) ? 1 : 0;
        stab_delta = stab_bad - snap_stab;
    endtask

    vec_t vecs[$];

    initial begin
        int r, n, c, f, b, p, s, snap, snap_late, saw_activity;
        logic [W-1:0]  rx;
        logic [EW-1:0] re;
        logic [LW-1:0] rl;

        vecs.push_back('{x: 8'd5, e: 16'b1011, e_len: 11'd4,    poke: 1'b0, exp_result: 8, exp_muls: 9,  exp_cycle: 55});
        vecs.push_back('{x: 8'd5, e: 16'd0,    e_len: 11'd0,    poke: 1'b0, exp_result: 1, exp_muls: 2,  exp_cycle: 13});
        vecs.push_back('{x: 8'd5, e: 16'b0001, e_len: 11'd4,    poke: 1'b1, exp_result: 5, exp_muls: 7,  exp_cycle: 43});
        vecs.push_back('{x: 8'd5, e: 16'h0003, e_len: 11'd2047, poke: 1'b0, exp_result: 8, exp_muls: 20, exp_cycle: 121});

        reset = 1'b1; start = 1'b0;
        in_x = '0; in_e = '0; in_e_len = '0;
        in_m = W'(MOD); in_r = W'(RMOD); in_r2 = W'(R2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_busy_done", int'({busy, done, mbus.mul_start}), 0);
        check_output("reset_result", int'(result), 0);
        check_output("reset_operands", int'({mbus.mul_a, mbus.mul_b, mbus.mul_m}), 0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].x, vecs[k].e, vecs[k].e_len, vecs[k].poke, r, n, c, f, b, p, s);
            check_output($sformatf("vec%0d_result", k), r, vecs[k].exp_result);
            check_output($sformatf("vec%0d_muls", k), n, vecs[k].exp_muls);
            check_output($sformatf("vec%0d_done_cycle", k), c, vecs[k].exp_cycle);
            check_output($sformatf("vec%0d_first_issue", k), f, 1);
            check_output($sformatf("vec%0d_busy", k), b, 1);
            check_output($sformatf("vec%0d_done_pulse", k), p, 1);
            check_output($sformatf("vec%0d_operand_stable", k), s, 0);
        end

        for (int k = 0; k < 10; k++) begin
            rx = W'($urandom_range(0, MOD - 1));
            re = EW'($urandom);
            rl = LW'($urandom_range(0, EW + 4));
            apply_stimulus(rx, re, rl, 1'b0, r, n, c, f, b, p, s);
            check_output($sformatf("rnd%0d_result", k), r, ref_pow(int'(rx), re, int'(rl)));
            check_output($sformatf("rnd%0d_muls", k), n, ref_muls(re, int'(rl)));
            check_output($sformatf("rnd%0d_done_cycle", k), c, ref_muls(re, int'(rl)) * (LAT + 1) + 1);
            check_output($sformatf("rnd%0d_operand_stable", k), s, 0);
        end

        // Abort during the third multiplication's wait, then a fresh run.
        @(negedge clk);
        in_x = 8'd5; in_e = 16'b1011; in_e_len = 11'd4; start = 1'b1;
        snap = mul_starts;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && (mul_starts - snap) < 3; k++) @(negedge clk);
        check_output("abort_reached_third_mul", mul_starts - snap, 3);
        repeat (2) @(negedge clk);
        snap_late = late_dones;
        reset = 1'b1;
        @(negedge clk);
        check_output("abort_reset_outputs", int'({busy, done, mbus.mul_start}), 0);
        check_output("abort_reset_operands", int'({mbus.mul_a, mbus.mul_b, mbus.mul_m, result}), 0);
        @(negedge clk);
        reset = 1'b0;
        saw_activity = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || mbus.mul_start !== 1'b0) saw_activity = 1;
        end
        check_output("abort_late_done_arrived", late_dones - snap_late, 1);
        check_output("abort_no_activity", saw_activity, 0);
        check_output("abort_result_cleared", int'(result), 0);

        apply_stimulus(8'd7, 16'd2, 11'd2, 1'b0, r, n, c, f, b, p, s);
        check_output("after_abort_result", r, 10);
        check_output("after_abort_muls", n, 5);
        check_output("after_abort_done_cycle", c, 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
